lbp_host: RTL and testbench

- Host-side counterpart of the LBP engine; sits on the far end of both engine interfaces.
- Acts as the gray-image responder: answers gray_req/gray_addr with gray_ready/gray_data from an internal 128x128 image memory.
- Acts as the result sink: captures every lbp_valid/lbp_addr/lbp_data write into a result memory.
- Tracks finish and exposes counters, a sticky protocol-error flag and a readback port for the checker.

---
 rtl/lbp_pkg.sv | 32 +++
 rtl/lbp_host_mem.sv | 34 +++
 rtl/lbp_host.sv | 125 ++++++++++++
 tb/tb_lbp_host.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lbp_pkg: shared FSM type, geometry constants and border test for lbp_host.
// Rev 1.0
// ---------------------------------------------------------------------------
package lbp_pkg;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 8;
  localparam int IMG_W      = 128;
  localparam int IMG_PIXELS = IMG_W * IMG_W;
  localparam int COL_W      = $clog2(IMG_W);
  localparam int ROW_W      = ADDR_W - COL_W;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // IMG_W is a power of two, so row/column are plain bit fields of the address.
  function automatic logic is_border(input logic [ADDR_W-1:0] addr);
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    col = addr[COL_W-1:0];
    row = addr[ADDR_W-1:COL_W];
    return (row == '0) || (row == ROW_W'(IMG_W - 1)) ||
           (col == '0) || (col == COL_W'(IMG_W - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lbp_host_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lbp_host_mem: one write port, one registered read port RAM (no array reset).
// Rev 1.0
// ---------------------------------------------------------------------------
module lbp_host_mem import lbp_pkg::*; #(
  parameter int AW    = ADDR_W,
  parameter int DW    = DATA_W,
  parameter int DEPTH = IMG_PIXELS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; stored contents survive a reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/lbp_host.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lbp_host: gray-image responder and result sink facing the LBP engine.
// Rev 1.0 | define LBP_HOST_BORDER_CHECK_EN to flag result writes on the border.
// ---------------------------------------------------------------------------
module lbp_host #(
  parameter int ADDR_W = lbp_pkg::ADDR_W,
  parameter int DATA_W = lbp_pkg::DATA_W,
  parameter int IMG_W  = lbp_pkg::IMG_W,
  parameter int CNT_W  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] gray_addr,
  input  logic              gray_req,
  output logic              gray_ready,
  output logic [DATA_W-1:0] gray_data,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic              lbp_valid,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  gray_rd_cnt,
  output logic [CNT_W-1:0]  lbp_wr_cnt,
  output logic              proto_err,
  output logic              done
);
  import lbp_pkg::*;

  localparam int PIXELS = IMG_W * IMG_W;

  state_t state;
  state_t state_nxt;
  logic   img_we;
  logic   img_re;
  logic   res_we;
  logic   err_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    img_we    = 1'b0;
    img_re    = 1'b0;
    res_we    = 1'b0;
    err_set   = 1'b0;
    case (state)
      LOAD: begin
        img_we  = load_en;
        err_set = gray_req | lbp_valid;
        if (start) state_nxt = SERVE;
      end
      SERVE: begin
        img_re  = gray_req;
        res_we  = lbp_valid;
        err_set = load_en;
        if (finish) state_nxt = DONE;
      end
      DONE: begin
        // Results may trail finish, so the sink stays open.
        res_we  = lbp_valid;
        err_set = gray_req;
      end
      default: state_nxt = LOAD;
    endcase
`ifdef LBP_HOST_BORDER_CHECK_EN
    if (res_we && is_border(lbp_addr)) err_set = 1'b1;
`endif
  end

  assign gray_ready = (state == SERVE);
  assign done       = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gray_rd_cnt <= '0;
      lbp_wr_cnt  <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (img_re && !(&gray_rd_cnt)) gray_rd_cnt <= gray_rd_cnt + CNT_W'(1);
      if (res_we && !(&lbp_wr_cnt))  lbp_wr_cnt  <= lbp_wr_cnt + CNT_W'(1);
      if (err_set)                   proto_err   <= 1'b1;
    end
  end

  lbp_host_mem #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (PIXELS)
  ) u_img_mem (
    .clk   (clk),
    .reset (reset),
    .we    (img_we),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (img_re),
    .raddr (gray_addr),
    .rdata (gray_data)
  );

  lbp_host_mem #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (PIXELS)
  ) u_res_mem (
    .clk   (clk),
    .reset (reset),
    .we    (res_we),
    .waddr (lbp_addr),
    .wdata (lbp_data),
    .re    (1'b1),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_lbp_host.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lbp_host: vector table, directed corner cases and randomized model check.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_lbp_host;

  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int CW   = 15;
  localparam int IW   = 128;
  localparam int NPIX = 1 << AW;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          start = 1'b0;
  logic [AW-1:0] gray_addr = '0;
  logic          gray_req = 1'b0;
  logic          gray_ready;
  logic [DW-1:0] gray_data;
  logic [AW-1:0] lbp_addr = '0;
  logic          lbp_valid = 1'b0;
  logic [DW-1:0] lbp_data = '0;
  logic          finish = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] gray_rd_cnt;
  logic [CW-1:0] lbp_wr_cnt;
  logic          proto_err;
  logic          done;

  lbp_host #(.ADDR_W(AW), .DATA_W(DW), .IMG_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .gray_addr(gray_addr),
    .gray_req(gray_req), .gray_ready(gray_ready), .gray_data(gray_data),
    .lbp_addr(lbp_addr), .lbp_valid(lbp_valid), .lbp_data(lbp_data),
    .finish(finish), .rd_addr(rd_addr), .rd_data(rd_data),
    .gray_rd_cnt(gray_rd_cnt), .lbp_wr_cnt(lbp_wr_cnt),
    .proto_err(proto_err), .done(done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0 = loading, 1 = serving, 2 = finished.
  logic [DW-1:0] m_img   [NPIX];
  logic [DW-1:0] m_res   [NPIX];
  bit            m_known [NPIX];
  int            m_phase;
  int            m_rcnt;
  int            m_wcnt;
  int            m_gray;
  int            m_rd;
  bit            m_rd_known;
  bit            m_err;

  typedef struct {
    int st, rq, ga, lv, la, ld, fn, ra;
    int e_rdy, e_gray, e_rcnt, e_wcnt, e_err, e_done, e_rd;
  } vec_t;
  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit m_border(input int a);
    int row = a / IW;
    int col = a % IW;
    return (row == 0) || (row == IW - 1) || (col == 0) || (col == IW - 1);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_rcnt = 0; m_wcnt = 0; m_gray = 0; m_rd = 0;
    m_rd_known = 1'b1; m_err = 1'b0;
  endtask

  task automatic model_capture();
    m_res[lbp_addr]   = lbp_data;
    m_known[lbp_addr] = 1'b1;
    if (m_wcnt < CMAX) m_wcnt++;
`ifdef LBP_HOST_BORDER_CHECK_EN
    if (m_border(int'(lbp_addr))) m_err = 1'b1;
`endif
  endtask

  task automatic model_edge();
    m_rd_known = m_known[rd_addr];
    m_rd       = int'(m_res[rd_addr]);
    if (m_phase == 0) begin
      if (load_en) m_img[load_addr] = load_data;
      if (gray_req || lbp_valid) m_err = 1'b1;
      if (start) m_phase = 1;
    end else if (m_phase == 1) begin
      if (gray_req) begin
        m_gray = int'(m_img[gray_addr]);
        if (m_rcnt < CMAX) m_rcnt++;
      end
      if (load_en) m_err = 1'b1;
      if (lbp_valid) model_capture();
      if (finish) m_phase = 2;
    end else begin
      if (lbp_valid) model_capture();
      if (gray_req) m_err = 1'b1;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_en = 1'b0; start = 1'b0; gray_req = 1'b0; lbp_valid = 1'b0; finish = 1'b0;
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1'b0;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic compare_model(input string t);
    check({t, ".ready"}, 32'(gray_ready),  32'(m_phase == 1));
    check({t, ".done"},  32'(done),        32'(m_phase == 2));
    check({t, ".gray"},  32'(gray_data),   32'(m_gray));
    check({t, ".rcnt"},  32'(gray_rd_cnt), 32'(m_rcnt));
    check({t, ".wcnt"},  32'(lbp_wr_cnt),  32'(m_wcnt));
    check({t, ".err"},   32'(proto_err),   32'(m_err));
    if (m_rd_known) check({t, ".rd"}, 32'(rd_data), 32'(m_rd));
  endtask

  initial begin
    logic [AW-1:0] last_la;
    int exp_border_err;
`ifdef LBP_HOST_BORDER_CHECK_EN
    exp_border_err = 1;
`else
    exp_border_err = 0;
`endif
    last_la = '0;

    //            st rq ga  lv la     ld     fn ra      rdy gray rcnt wcnt err done rd
    tbl[0]  = '{1, 0, 0,  0, 0,     0,     0, 0,      1,  0,   0,   0,   0,  0,   -1};
    tbl[1]  = '{0, 1, 0,  0, 0,     0,     0, 0,      1,  0,   1,   0,   0,  0,   -1};
    tbl[2]  = '{0, 1, 1,  0, 0,     0,     0, 0,      1,  1,   2,   0,   0,  0,   -1};
    tbl[3]  = '{0, 1, 2,  0, 0,     0,     0, 0,      1,  2,   3,   0,   0,  0,   -1};
    tbl[4]  = '{0, 1, 3,  0, 0,     0,     0, 0,      1,  3,   4,   0,   0,  0,   -1};
    tbl[5]  = '{0, 1, 4,  0, 0,     0,     0, 0,      1,  4,   5,   0,   0,  0,   -1};
    tbl[6]  = '{0, 1, 5,  0, 0,     0,     0, 0,      1,  5,   6,   0,   0,  0,   -1};
    tbl[7]  = '{0, 0, 0,  1, 129,   'hA5,  0, 129,    1,  5,   6,   1,   0,  0,   -1};
    tbl[8]  = '{0, 0, 0,  1, 130,   'h3C,  0, 129,    1,  5,   6,   2,   0,  0,   'hA5};
    tbl[9]  = '{0, 0, 0,  0, 0,     0,     0, 130,    1,  5,   6,   2,   0,  0,   'h3C};
    tbl[10] = '{0, 0, 0,  0, 0,     0,     1, 130,    0,  5,   6,   2,   0,  1,   'h3C};
    tbl[11] = '{0, 0, 0,  1, 16254, 'h7F,  0, 16254,  0,  5,   6,   3,   0,  1,   -1};
    tbl[12] = '{0, 0, 0,  0, 0,     0,     0, 16254,  0,  5,   6,   3,   0,  1,   'h7F};
    tbl[13] = '{0, 1, 9,  0, 0,     0,     0, 16254,  0,  5,   6,   3,   1,  1,   'h7F};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 32'(gray_ready), 0);
    check("rst.gray",  32'(gray_data), 0);
    check("rst.rd",    32'(rd_data), 0);
    check("rst.rcnt",  32'(gray_rd_cnt), 0);
    check("rst.wcnt",  32'(lbp_wr_cnt), 0);
    check("rst.err",   32'(proto_err), 0);
    check("rst.done",  32'(done), 0);
    model_reset();
    reset = 1'b1;

    // Preload img_mem[i] = i[7:0].
    for (int i = 0; i < NPIX; i++) begin
      load_en = 1'b1; load_addr = AW'(i); load_data = DW'(i);
      cycle();
    end
    idle();

    // Read request while loading.
    gray_req = 1'b1; gray_addr = AW'(3);
    cycle();
    idle();
    check("load_req.err",   32'(proto_err), 1);
    check("load_req.gray",  32'(gray_data), 0);
    check("load_req.rcnt",  32'(gray_rd_cnt), 0);
    check("load_req.ready", 32'(gray_ready), 0);
    cycle();
    check("load_req.sticky", 32'(proto_err), 1);
    pulse_reset();
    check("rst2.err", 32'(proto_err), 0);

    // Vector table: start, reads, writes, readback, finish, trailing write.
    foreach (tbl[i]) begin
      start     = (tbl[i].st != 0);
      gray_req  = (tbl[i].rq != 0);
      gray_addr = AW'(tbl[i].ga);
      lbp_valid = (tbl[i].lv != 0);
      lbp_addr  = AW'(tbl[i].la);
      lbp_data  = DW'(tbl[i].ld);
      finish    = (tbl[i].fn != 0);
      rd_addr   = AW'(tbl[i].ra);
      cycle();
      check($sformatf("vec%0d.ready", i), 32'(gray_ready),  tbl[i].e_rdy);
      check($sformatf("vec%0d.gray", i),  32'(gray_data),   tbl[i].e_gray);
      check($sformatf("vec%0d.rcnt", i),  32'(gray_rd_cnt), tbl[i].e_rcnt);
      check($sformatf("vec%0d.wcnt", i),  32'(lbp_wr_cnt),  tbl[i].e_wcnt);
      check($sformatf("vec%0d.err", i),   32'(proto_err),   tbl[i].e_err);
      check($sformatf("vec%0d.done", i),  32'(done),        tbl[i].e_done);
      if (tbl[i].e_rd >= 0) check($sformatf("vec%0d.rd", i), 32'(rd_data), tbl[i].e_rd);
    end
    idle();

    // Result write on the border (row 0, column 127).
    pulse_reset();
    start = 1'b1;
    cycle();
    idle();
    lbp_valid = 1'b1; lbp_addr = AW'(127); lbp_data = 8'h11; rd_addr = AW'(127);
    cycle();
    idle();
    check("border.err", 32'(proto_err), exp_border_err);
    cycle();
    check("border.rd", 32'(rd_data), 32'h11);

    // Asynchronous reset in the middle of serving, then image retention.
    for (int k = 0; k < 100; k++) begin
      gray_req = 1'b1; gray_addr = AW'($urandom);
      cycle();
    end
    idle();
    check("mid.rcnt_pre", 32'(gray_rd_cnt), 100);
    reset = 1'b0;
    #2;
    check("mid.rcnt",  32'(gray_rd_cnt), 0);
    check("mid.wcnt",  32'(lbp_wr_cnt), 0);
    check("mid.ready", 32'(gray_ready), 0);
    check("mid.err",   32'(proto_err), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b1;
    cycle();
    idle();
    gray_req = 1'b1; gray_addr = AW'(100);
    cycle();
    idle();
    check("mid.retain", 32'(gray_data), 100);
    check("mid.rcnt1",  32'(gray_rd_cnt), 1);

    // Counter saturation for both counters.
    pulse_reset();
    start = 1'b1;
    cycle();
    idle();
    for (int k = 0; k < CMAX + 3; k++) begin
      gray_req = 1'b1; gray_addr = AW'($urandom);
      lbp_valid = 1'b1; lbp_addr = AW'(5000); lbp_data = DW'($urandom);
      rd_addr = AW'(5000);
      cycle();
      if (k == CMAX - 2) check("sat.rcnt_below", 32'(gray_rd_cnt), CMAX - 1);
    end
    idle();
    check("sat.rcnt", 32'(gray_rd_cnt), CMAX);
    check("sat.wcnt", 32'(lbp_wr_cnt), CMAX);
    cycle();
    compare_model("sat");

    // Randomized run against the reference model.
    pulse_reset();
    for (int k = 0; k < 200; k++) begin
      idle();
      load_en = 1'($urandom_range(1)); load_addr = AW'($urandom); load_data = DW'($urandom);
      rd_addr = AW'($urandom);
      cycle();
      compare_model("rload");
    end
    idle();
    start = 1'b1;
    cycle();
    compare_model("rstart");
    for (int k = 0; k < 2000; k++) begin
      idle();
      gray_req  = 1'($urandom_range(1));
      gray_addr = AW'($urandom);
      lbp_valid = 1'($urandom_range(1));
      lbp_addr  = AW'($urandom);
      lbp_data  = DW'($urandom);
      load_en   = ($urandom_range(499) == 0);
      rd_addr   = ($urandom_range(1) == 1) ? last_la : AW'($urandom);
      finish    = (k == 1999);
      cycle();
      compare_model("rserve");
      if (lbp_valid) last_la = lbp_addr;
    end
    for (int k = 0; k < 50; k++) begin
      idle();
      lbp_valid = 1'($urandom_range(1));
      lbp_addr  = AW'($urandom);
      lbp_data  = DW'($urandom);
      gray_req  = (k == 40);
      rd_addr   = last_la;
      cycle();
      compare_model("rdone");
      if (lbp_valid) last_la = lbp_addr;
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
